// File: rtl/arith_pkg.sv
// Shared types and helpers for the sequential add/subtract unit.
// Holds the FSM state enum, operation mode constants and a width sanity check.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // True when the operand width splits evenly into whole chunks.
  function automatic bit width_ok(input int unsigned width, input int unsigned chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder slice.
// One instance is time-shared across all chunks of an operation.
module chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  always_comb begin
    logic c;
    c = cin;
    s = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per clock
// through one shared adder slice, with valid/ready handshakes on both sides.
module seq_addsub
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NCH   = WIDTH / CHUNK;
  localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned MSB   = WIDTH - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  if (!width_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("seq_addsub: WIDTH must be a nonzero multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cy_q, cy_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [POS_W-1:0] pos_c;
  logic [CHUNK-1:0] x_c, y_c, s_c;
  logic             cout_c;

  // Bit offset of the chunk being processed this cycle.
  assign pos_c = POS_W'(idx_q) * POS_W'(CHUNK);
  assign x_c   = a_q[pos_c +: CHUNK];
  assign y_c   = b_q[pos_c +: CHUNK];

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .x    (x_c),
    .y    (y_c),
    .cin  (cy_q),
    .s    (s_c),
    .cout (cout_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      idx_q       <= '0;
      cy_q        <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      idx_q       <= idx_d;
      cy_q        <= cy_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    idx_d       = idx_q;
    cy_d        = cy_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          // Subtraction becomes a + ~b with the initial carry-in set.
          a_d        = a;
          b_d        = (sub == OP_SUB) ? ~b : b;
          cy_d       = sub;
          idx_d      = '0;
          state_d    = CALC;
          in_ready_d = 1'b0;
        end
      end

      CALC: begin
        res_d[pos_c +: CHUNK] = s_c;
        cy_d  = cout_c;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          // Flags are taken from the fully assembled result.
          idx_d       = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
          ovf_d       = (a_q[MSB] == b_q[MSB]) && (res_d[MSB] != a_q[MSB]);
          zero_d      = (res_d == '0);
        end
      end

      DONE: begin
        out_valid_d = 1'b1;
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign carry     = cy_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Randomized and directed bench for seq_addsub in three width/chunk configurations,
// checked against an arithmetic reference model.
module tb_seq_addsub;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic        in_valid_a  [3];
  logic        sub_a       [3];
  logic        out_ready_a [3];
  logic [15:0] a_a         [3];
  logic [15:0] b_a         [3];

  logic        in_ready_o  [3];
  logic        out_valid_o [3];
  logic        cy_o        [3];
  logic        ovf_o       [3];
  logic        zero_o      [3];
  logic [15:0] res_o       [3];

  logic [15:0] r0;
  logic [3:0]  r1;
  logic [7:0]  r2;

  assign res_o[0] = r0;
  assign res_o[1] = 16'(r1);
  assign res_o[2] = 16'(r2);

  seq_addsub #(.WIDTH(16), .CHUNK(4)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[0]), .in_ready(in_ready_o[0]),
    .a(a_a[0]), .b(b_a[0]), .sub(sub_a[0]), .out_valid(out_valid_o[0]),
    .out_ready(out_ready_a[0]), .result(r0), .carry(cy_o[0]),
    .overflow(ovf_o[0]), .zero(zero_o[0])
  );

  seq_addsub #(.WIDTH(4), .CHUNK(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[1]), .in_ready(in_ready_o[1]),
    .a(a_a[1][3:0]), .b(b_a[1][3:0]), .sub(sub_a[1]), .out_valid(out_valid_o[1]),
    .out_ready(out_ready_a[1]), .result(r1), .carry(cy_o[1]),
    .overflow(ovf_o[1]), .zero(zero_o[1])
  );

  seq_addsub #(.WIDTH(8), .CHUNK(8)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[2]), .in_ready(in_ready_o[2]),
    .a(a_a[2][7:0]), .b(b_a[2][7:0]), .sub(sub_a[2]), .out_valid(out_valid_o[2]),
    .out_ready(out_ready_a[2]), .result(r2), .carry(cy_o[2]),
    .overflow(ovf_o[2]), .zero(zero_o[2])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int w_of(input int d);
    case (d)
      0:       return 16;
      1:       return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int nch_of(input int d);
    case (d)
      0:       return 4;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input int w, input logic [15:0] a, input logic [15:0] b, input logic sub,
                       output logic [15:0] r, output logic c, output logic o);
    longint m, ia, ib, ur, sa, sb, st;
    m  = longint'(1) << w;
    ia = longint'(a);
    ib = longint'(b);
    ur = sub ? (ia - ib) : (ia + ib);
    r  = 16'(((ur % m) + m) % m);
    c  = sub ? (ia >= ib) : (ur >= m);
    sa = (ia >= m / 2) ? ia - m : ia;
    sb = (ib >= m / 2) ? ib - m : ib;
    st = sub ? (sa - sb) : (sa + sb);
    o  = (st < -(m / 2)) || (st >= (m / 2));
  endtask

  task automatic do_op(input int d, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input int hold);
    int          w;
    logic [15:0] m;
    logic [15:0] er;
    logic        ec, eo;
    int          lat;
    w = w_of(d);
    m = 16'((32'd1 << w) - 32'd1);
    model(w, a & m, b & m, sub, er, ec, eo);

    @(negedge clk);
    chk($sformatf("d%0d in_ready_idle", d), 32'(in_ready_o[d]), 32'd1);
    a_a[d] = a & m;
    b_a[d] = b & m;
    sub_a[d] = sub;
    in_valid_a[d] = 1'b1;
    @(negedge clk);
    // Accept edge has passed; scramble inputs to show they are ignored.
    in_valid_a[d] = 1'b0;
    a_a[d] = 16'($urandom);
    b_a[d] = 16'($urandom);
    sub_a[d] = ~sub;
    lat = 0;
    while (lat < 40 && !out_valid_o[d]) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("d%0d latency", d), 32'(lat), 32'(nch_of(d)));
    chk($sformatf("d%0d result", d), 32'(res_o[d]), 32'(er));
    chk($sformatf("d%0d carry", d), 32'(cy_o[d]), 32'(ec));
    chk($sformatf("d%0d overflow", d), 32'(ovf_o[d]), 32'(eo));
    chk($sformatf("d%0d zero", d), 32'(zero_o[d]), 32'(er == 16'd0));

    for (int i = 0; i < hold; i++) begin
      a_a[d] = 16'($urandom);
      b_a[d] = 16'($urandom);
      in_valid_a[d] = 1'($urandom);
      @(negedge clk);
      chk($sformatf("d%0d hold out_valid", d), 32'(out_valid_o[d]), 32'd1);
      chk($sformatf("d%0d hold in_ready", d), 32'(in_ready_o[d]), 32'd0);
      chk($sformatf("d%0d hold result", d), 32'(res_o[d]), 32'(er));
      chk($sformatf("d%0d hold flags", d),
          32'({cy_o[d], ovf_o[d], zero_o[d]}), 32'({ec, eo, er == 16'd0}));
    end

    in_valid_a[d] = 1'b0;
    out_ready_a[d] = 1'b1;
    @(negedge clk);
    out_ready_a[d] = 1'b0;
    chk($sformatf("d%0d released out_valid", d), 32'(out_valid_o[d]), 32'd0);
    chk($sformatf("d%0d released in_ready", d), 32'(in_ready_o[d]), 32'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s d%0d in_ready", tag, d), 32'(in_ready_o[d]), 32'd1);
      chk($sformatf("%s d%0d out_valid", tag, d), 32'(out_valid_o[d]), 32'd0);
      chk($sformatf("%s d%0d result", tag, d), 32'(res_o[d]), 32'd0);
      chk($sformatf("%s d%0d flags", tag, d),
          32'({cy_o[d], ovf_o[d], zero_o[d]}), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid_a[d]  = 1'b0;
      sub_a[d]       = 1'b0;
      out_ready_a[d] = 1'b0;
      a_a[d]         = '0;
      b_a[d]         = '0;
    end
    @(negedge clk);
    @(negedge clk);
    chk_reset_state("por");
    rst = 1'b0;

    // Directed 16/4 vectors, including back-pressure with input toggling.
    do_op(0, 16'hFFFF, 16'h0001, 1'b0, 0);
    do_op(0, 16'h7FFF, 16'h0001, 1'b0, 5);
    do_op(0, 16'h0005, 16'h0007, 1'b1, 0);
    do_op(0, 16'h8000, 16'h0001, 1'b1, 0);
    do_op(0, 16'h1234, 16'h1234, 1'b1, 0);

    // Abort an operation two cycles into CALC.
    @(negedge clk);
    a_a[0] = 16'h0F0F;
    b_a[0] = 16'h1111;
    sub_a[0] = 1'b0;
    in_valid_a[0] = 1'b1;
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_state("abort_async");
    @(negedge clk);
    chk_reset_state("abort_held");
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort no out_valid", 32'(out_valid_o[0]), 32'd0);
      chk("abort in_ready", 32'(in_ready_o[0]), 32'd1);
    end

    // Random 16/4 operations.
    for (int i = 0; i < 150; i++)
      do_op(0, 16'($urandom), 16'($urandom), 1'($urandom), (i % 10 == 0) ? 2 : 0);

    // Exhaustive 4/1 sweep in both modes.
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          do_op(1, 16'(x), 16'(y), 1'(s), 0);

    // Single-cycle 8/8 configuration.
    do_op(2, 16'h00FF, 16'h0001, 1'b0, 0);
    do_op(2, 16'h0080, 16'h0001, 1'b1, 0);
    for (int i = 0; i < 40; i++)
      do_op(2, 16'($urandom), 16'($urandom), 1'($urandom), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
- Multi-cycle, parametrised successor to the 4-bit combinational `sum` adder.
- Adds or subtracts two WIDTH-bit operands, CHUNK bits per clock, through one shared CHUNK-bit adder slice.
- Valid/ready handshakes on input and output.
- Produces sum, carry/no-borrow, signed overflow and zero flags.
- Serves as the arithmetic unit for the wider datapath blocks that follow it.

Parameters:
- WIDTH, 16: operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4: bits processed per cycle; 1 <= CHUNK <= WIDTH.
- NCH, WIDTH/CHUNK: derived localparam; number of compute cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and mode presented.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  first operand.
- b  in  WIDTH  second operand.
- sub  in  1  0 = a+b, 1 = a-b.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  sum or difference, modulo 2^WIDTH.
- carry  out  1  add: carry out of MSB; sub: 1 = no borrow (a >= b unsigned).
- overflow  out  1  two's-complement signed overflow.
- zero  out  1  result == 0.

Behaviour:
- Reset (async, any state): state IDLE, in_ready=1, out_valid=0, result=0, carry=0, overflow=0, zero=0; internal operand registers and chunk counter cleared.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b^{WIDTH{sub}} and sub (the initial carry-in), clear chunk index, go to CALC.
  - CALC: in_ready=0, out_valid=0. Each cycle, process chunk k = bits [k*CHUNK +: CHUNK] with the running carry and write that slice of the result register. After chunk NCH-1, go to DONE.
  - DONE: out_valid=1, in_ready=0; result and flags held stable. On out_ready, go to IDLE (out_valid=0 the next cycle).
- Latency: out_valid rises exactly NCH cycles after the accept edge. With CHUNK=WIDTH, latency is 1.
- Throughput: one operation per NCH+2 cycles minimum. There is no accept in DONE, even when out_ready is high in the same cycle.
- Arithmetic:
  - Subtraction is a + ~b + 1.
  - carry = carry out of the final chunk.
  - overflow = (a[MSB] == b'[MSB]) && (result[MSB] != a[MSB]), where b' is the inverted-or-not operand.
  - zero is evaluated on the full registered result when entering DONE.
- Flags and result are valid only while out_valid=1. Outside DONE they may show partial values, except after reset, when they are 0.
- Inputs a, b and sub are ignored except in the accept cycle; changes during CALC have no effect.
- in_valid held high through DONE is not accepted until IDLE.
- Reset during CALC or DONE aborts the operation; no out_valid for the aborted operation.
- Back-pressure: out_ready low holds DONE indefinitely with all outputs stable.

Decomposition:
- Shared package (arith_pkg): FSM state enum (IDLE, CALC, DONE); op mode constants OP_ADD=0, OP_SUB=1; width-check function used by an elaboration-time assertion that WIDTH % CHUNK == 0.
- Sub-module chunk_adder: combinational CHUNK-bit ripple adder with ports x, y, cin, s, cout. It is instantiated once and reused every CALC cycle.
- The FSM, counter and registers stay in seq_addsub.

Test Plan:
- WIDTH=16, CHUNK=4, add 0xFFFF+0x0001 -> result 0x0000, carry=1, overflow=0, zero=1; out_valid exactly 4 cycles after the accept edge.
- Add 0x7FFF+0x0001 -> 0x8000, carry=0, overflow=1, zero=0.
- Sub 0x0005-0x0007 -> 0xFFFE, carry=0, overflow=0. Sub 0x8000-0x0001 -> 0x7FFF, carry=1, overflow=1.
- Hold out_ready low 5 cycles in DONE while toggling a, b and in_valid -> result and flags unchanged, in_ready=0; the next op is accepted only after the IDLE return.
- Assert rst 2 cycles into CALC -> all outputs 0 and in_ready=1 while reset is high and after release; out_valid never pulses for the aborted op.
- WIDTH=4, CHUNK=1: exhaustive sweep of all 256 a/b pairs in both modes against a behavioural model -> every result, carry and overflow matches, each with latency 4. Also WIDTH=8, CHUNK=8: latency 1.
